// File: rtl/big_clk_timer_if.sv
`timescale 1ns/1ps
// Control and status bundle of big_clk_timer: period/enable control, per-channel sleep requests, tick and wake status.
interface big_clk_timer_if #(
    parameter int CHANNELS = 2,
    parameter int PERIOD_W = 16,
    parameter int VAL_W    = 11
);
    logic                      enable;
    logic                      period_load;
    logic [PERIOD_W-1:0]       period_in;
    logic [CHANNELS-1:0]       slp_req;
    logic [CHANNELS*VAL_W-1:0] slp_val;
    logic                      posedge_big_clk;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       wake;
    logic [15:0]               time_units;

    modport master (
        output enable, period_load, period_in, slp_req, slp_val,
        input  posedge_big_clk, busy, wake, time_units
    );

    modport slave (
        input  enable, period_load, period_in, slp_req, slp_val,
        output posedge_big_clk, busy, wake, time_units
    );
endinterface

// File: rtl/big_clk_timer.sv
`timescale 1ns/1ps
// Programmable time base (one tick per period clk cycles) driving independent per-channel sleep timers.
// Latency: tick, busy and wake are registered, one clk after the deciding edge; no backpressure, enable freezes everything.
module big_clk_timer #(
    parameter int CHANNELS       = 2,
    parameter int PERIOD_W       = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int VAL_W          = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    big_clk_timer_if.slave bus
);
    localparam int                  REM_W      = 10;
    localparam logic [PERIOD_W-1:0] DEF_PERIOD = PERIOD_W'(DEFAULT_PERIOD);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] pending_q;
    logic [PERIOD_W-1:0] period_in_clamped;
    logic                pulse_q;
    logic [15:0]         tu_q;
    logic                wrap;
    logic [REM_W-1:0]    rem_q [CHANNELS];
    logic [CHANNELS-1:0] busy_q;
    logic [CHANNELS-1:0] wake_q;

    function automatic logic [REM_W-1:0] clamp_sleep(input logic signed [VAL_W-1:0] v);
        int vi;
        vi = int'(v);
        if (vi < 1)   return REM_W'(1);
        if (vi > 999) return REM_W'(999);
        return REM_W'(vi);
    endfunction

    assign period_in_clamped = (bus.period_in < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.period_in;
    assign wrap              = bus.enable && (cnt_q == period_q - PERIOD_W'(1));

    // Period changes only land at a wrap, so the counter never overshoots a shortened period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            period_q  <= DEF_PERIOD;
            pending_q <= DEF_PERIOD;
            pulse_q   <= 1'b0;
            tu_q      <= '0;
        end else begin
            if (bus.period_load) pending_q <= period_in_clamped;
            pulse_q <= wrap;
            if (wrap) begin
                cnt_q    <= '0;
                period_q <= pending_q;
                tu_q     <= tu_q + 16'd1;
            end else if (bus.enable) begin
                cnt_q <= cnt_q + PERIOD_W'(1);
            end
        end
    end

    // A request overrides both a coincident decrement and a coincident expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            wake_q <= '0;
            for (int i = 0; i < CHANNELS; i++) rem_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                wake_q[i] <= 1'b0;
                if (bus.slp_req[i]) begin
                    rem_q[i]  <= clamp_sleep(bus.slp_val[i*VAL_W +: VAL_W]);
                    busy_q[i] <= 1'b1;
                end else if (wrap && busy_q[i]) begin
                    rem_q[i] <= rem_q[i] - REM_W'(1);
                    if (rem_q[i] == REM_W'(1)) begin
                        busy_q[i] <= 1'b0;
                        wake_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.posedge_big_clk = pulse_q;
    assign bus.busy            = busy_q;
    assign bus.wake            = wake_q;
    assign bus.time_units      = tu_q;
endmodule
